// File: rtl/flash_audio_sequencer.sv
// -----------------------------------------------------------------------------
// flash_audio_sequencer
//
// Owns the flash_manager command port. It runs record sessions (erase, then
// one write per audio sample strobe) and looped playback sessions (one read
// per strobe, wrapping at the recorded length).
//
// Each flash command is a one-cycle pulse. A command is issued only while the
// manager is idle. A guard cycle after every read or write pulse lets a
// manager that raises busy one cycle late still be honoured.
//
// Ports:
//   clock, reset         system clock; asynchronous active-high reset
//   ready                one-cycle 48 kHz sample strobe
//   rec_start,
//   play_start, stop     one-cycle debounced command pulses
//                        (priority: stop > rec_start > play_start)
//   audio_in[17:0]       codec sample; bits [17:2] are recorded
//   audio_out[17:0]      playback sample {word,2'b00}; 0 outside PLAY
//   fm_reset             one-cycle pulse that starts an erase
//   fm_writemode         1 = erase/write, 0 = read
//   fm_wdata, fm_dowrite write word and one-cycle write pulse
//   fm_raddr, fm_doread  read address and one-cycle read pulse
//   fm_frdata, fm_busy   read data and busy flag from the manager
//   state[2:0]           FSM code: IDLE=0 ERASE=1 ERASE_WAIT=2 RECORD=3
//                        PLAY=4 DRAIN=5
//   length[22:0]         number of words recorded in the last session
//   full                 the last recording hit MAX_SAMPLES
//   xrun                 sticky flag: a sample strobe was missed
// -----------------------------------------------------------------------------
module flash_audio_sequencer #(
  parameter int MAX_SAMPLES = 524288
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        rec_start,
  input  logic        play_start,
  input  logic        stop,
  input  logic [17:0] audio_in,
  output logic [17:0] audio_out,
  output logic        fm_reset,
  output logic        fm_writemode,
  output logic [15:0] fm_wdata,
  output logic        fm_dowrite,
  output logic [22:0] fm_raddr,
  output logic        fm_doread,
  input  logic [15:0] fm_frdata,
  input  logic        fm_busy,
  output logic [2:0]  state,
  output logic [22:0] length,
  output logic        full,
  output logic        xrun
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ERASE      = 3'd1,
    S_ERASE_WAIT = 3'd2,
    S_RECORD     = 3'd3,
    S_PLAY       = 3'd4,
    S_DRAIN      = 3'd5
  } state_t;

  // 24 bits so that a capacity of exactly 2^23 words can still be compared.
  localparam logic [23:0] MAX_W = 24'(MAX_SAMPLES);

  // Next read address, wrapping to 0 after the last recorded word.
  function automatic logic [22:0] next_ptr(input logic [22:0] ptr,
                                           input logic [22:0] len);
    if (ptr == len - 23'd1) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + 23'd1;
    end
  endfunction

  state_t      state_q, state_d;
  logic [17:0] audio_out_q, audio_out_d;
  logic        fm_reset_q, fm_reset_d;
  logic        fm_writemode_q, fm_writemode_d;
  logic [15:0] fm_wdata_q, fm_wdata_d;
  logic        fm_dowrite_q, fm_dowrite_d;
  logic [22:0] fm_raddr_q, fm_raddr_d;
  logic        fm_doread_q, fm_doread_d;
  logic [22:0] length_q, length_d;
  logic        full_q, full_d;
  logic        xrun_q, xrun_d;
  logic [22:0] rptr_q, rptr_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] latch_q, latch_d;
  logic        rd_out_q, rd_out_d;
  logic        guard_q, guard_d;
  logic        busy_seen_q, busy_seen_d;
  logic        stop_lat_q, stop_lat_d;

  logic        flash_free;
  logic        rd_done;
  logic        pend_any;
  logic [15:0] pend_word;
  logic        last_word;
  logic        unused_audio_lsbs;

  // The two codec LSBs are never stored.
  assign unused_audio_lsbs = ^audio_in[1:0];

  // The manager may take a new command only when it is not busy. The flag is
  // also held low during the pulse cycle and the guard cycle that follows,
  // because busy is not yet trustworthy in those cycles.
  assign flash_free = !fm_busy && !fm_dowrite_q && !fm_doread_q && !guard_q;

  // An outstanding read has finished once busy is low outside the pulse and
  // guard cycles.
  assign rd_done    = rd_out_q && !fm_doread_q && !guard_q && !fm_busy;

  // A strobe in this cycle takes priority over the word already pending, so
  // the write can go out one cycle after the strobe.
  assign pend_any   = ready | pend_vld_q;
  assign pend_word  = ready ? audio_in[17:2] : pend_q;
  assign last_word  = (({1'b0, length_q} + 24'd1) == MAX_W);

  always_comb begin
    state_d        = state_q;
    audio_out_d    = audio_out_q;
    fm_reset_d     = 1'b0;
    fm_writemode_d = fm_writemode_q;
    fm_wdata_d     = fm_wdata_q;
    fm_dowrite_d   = 1'b0;
    fm_raddr_d     = fm_raddr_q;
    fm_doread_d    = 1'b0;
    length_d       = length_q;
    full_d         = full_q;
    xrun_d         = xrun_q;
    rptr_d         = rptr_q;
    pend_d         = pend_q;
    pend_vld_d     = pend_vld_q;
    latch_d        = latch_q;
    rd_out_d       = rd_out_q;
    guard_d        = fm_dowrite_q | fm_doread_q;
    busy_seen_d    = busy_seen_q;
    stop_lat_d     = stop_lat_q;

    if (rd_done) begin
      latch_d  = fm_frdata;
      rd_out_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        audio_out_d    = '0;
        fm_writemode_d = 1'b0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (rec_start) begin
          state_d        = S_ERASE;
          fm_reset_d     = 1'b1;
          fm_writemode_d = 1'b1;
          length_d       = '0;
          full_d         = 1'b0;
          xrun_d         = 1'b0;
          pend_vld_d     = 1'b0;
          busy_seen_d    = 1'b0;
          stop_lat_d     = 1'b0;
        end else if (play_start && (length_q != '0)) begin
          state_d  = S_PLAY;
          xrun_d   = 1'b0;
          rptr_d   = '0;
          latch_d  = '0;
          rd_out_d = 1'b0;
        end
      end

      S_ERASE: begin
        if (stop) begin
          stop_lat_d = 1'b1;
        end
        state_d = S_ERASE_WAIT;
      end

      // An erase cannot be aborted. A stop is remembered and acted on only
      // once the manager has finished.
      S_ERASE_WAIT: begin
        if (stop) begin
          stop_lat_d = 1'b1;
        end
        if (fm_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          stop_lat_d  = 1'b0;
          if (stop_lat_q || stop) begin
            state_d        = S_IDLE;
            fm_writemode_d = 1'b0;
          end else begin
            state_d = S_RECORD;
          end
        end
      end

      S_RECORD: begin
        if (stop) begin
          state_d    = S_DRAIN;
          pend_vld_d = 1'b0;
        end else begin
          if (ready && pend_vld_q) begin
            xrun_d = 1'b1;
          end
          if (pend_any && flash_free) begin
            fm_dowrite_d = 1'b1;
            fm_wdata_d   = pend_word;
            pend_vld_d   = 1'b0;
            length_d     = length_q + 23'd1;
            if (last_word) begin
              full_d  = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            pend_vld_d = pend_any;
            pend_d     = pend_word;
          end
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_d     = S_DRAIN;
          audio_out_d = '0;
        end else if (ready) begin
          audio_out_d = {latch_q, 2'b00};
          if (flash_free && !rd_out_q) begin
            fm_doread_d = 1'b1;
            fm_raddr_d  = rptr_q;
            rptr_d      = next_ptr(rptr_q, length_q);
            rd_out_d    = 1'b1;
          end else begin
            xrun_d = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        audio_out_d = '0;
        pend_vld_d  = 1'b0;
        if (flash_free) begin
          state_d        = S_IDLE;
          fm_writemode_d = 1'b0;
          rd_out_d       = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      audio_out_q    <= '0;
      fm_reset_q     <= 1'b0;
      fm_writemode_q <= 1'b0;
      fm_wdata_q     <= '0;
      fm_dowrite_q   <= 1'b0;
      fm_raddr_q     <= '0;
      fm_doread_q    <= 1'b0;
      length_q       <= '0;
      full_q         <= 1'b0;
      xrun_q         <= 1'b0;
      rptr_q         <= '0;
      pend_q         <= '0;
      pend_vld_q     <= 1'b0;
      latch_q        <= '0;
      rd_out_q       <= 1'b0;
      guard_q        <= 1'b0;
      busy_seen_q    <= 1'b0;
      stop_lat_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      audio_out_q    <= audio_out_d;
      fm_reset_q     <= fm_reset_d;
      fm_writemode_q <= fm_writemode_d;
      fm_wdata_q     <= fm_wdata_d;
      fm_dowrite_q   <= fm_dowrite_d;
      fm_raddr_q     <= fm_raddr_d;
      fm_doread_q    <= fm_doread_d;
      length_q       <= length_d;
      full_q         <= full_d;
      xrun_q         <= xrun_d;
      rptr_q         <= rptr_d;
      pend_q         <= pend_d;
      pend_vld_q     <= pend_vld_d;
      latch_q        <= latch_d;
      rd_out_q       <= rd_out_d;
      guard_q        <= guard_d;
      busy_seen_q    <= busy_seen_d;
      stop_lat_q     <= stop_lat_d;
    end
  end

  assign state        = state_q;
  assign audio_out    = audio_out_q;
  assign fm_reset     = fm_reset_q;
  assign fm_writemode = fm_writemode_q;
  assign fm_wdata     = fm_wdata_q;
  assign fm_dowrite   = fm_dowrite_q;
  assign fm_raddr     = fm_raddr_q;
  assign fm_doread    = fm_doread_q;
  assign length       = length_q;
  assign full         = full_q;
  assign xrun         = xrun_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for flash_audio_sequencer. Two instances share the stimulus:
// u_main uses the default capacity and u_cap uses a capacity of 4 words.
// Each instance has its own flash_manager stand-in with busy timing and
// storage.
// -----------------------------------------------------------------------------
module tb_flash_audio_sequencer;

  localparam int ERASE_CYC = 100;
  localparam int WR_CYC    = 4;
  localparam int RD_CYC    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ready, rec_start, play_start, stop;
  logic [17:0] audio_in;

  logic [1:0][17:0] aout;
  logic [1:0]       fmr, wm, dw, dr, busy, fullo, xr;
  logic [1:0][15:0] wd, frd;
  logic [1:0][22:0] ra, len;
  logic [1:0][2:0]  st;

  int total = 0;
  int bad   = 0;

  flash_audio_sequencer u_main (
    .clock(clk), .reset(rst), .ready(ready), .rec_start(rec_start),
    .play_start(play_start), .stop(stop), .audio_in(audio_in),
    .audio_out(aout[0]), .fm_reset(fmr[0]), .fm_writemode(wm[0]),
    .fm_wdata(wd[0]), .fm_dowrite(dw[0]), .fm_raddr(ra[0]),
    .fm_doread(dr[0]), .fm_frdata(frd[0]), .fm_busy(busy[0]),
    .state(st[0]), .length(len[0]), .full(fullo[0]), .xrun(xr[0])
  );

  flash_audio_sequencer #(.MAX_SAMPLES(4)) u_cap (
    .clock(clk), .reset(rst), .ready(ready), .rec_start(rec_start),
    .play_start(play_start), .stop(stop), .audio_in(audio_in),
    .audio_out(aout[1]), .fm_reset(fmr[1]), .fm_writemode(wm[1]),
    .fm_wdata(wd[1]), .fm_dowrite(dw[1]), .fm_raddr(ra[1]),
    .fm_doread(dr[1]), .fm_frdata(frd[1]), .fm_busy(busy[1]),
    .state(st[1]), .length(len[1]), .full(fullo[1]), .xrun(xr[1])
  );

  // ---------------- flash_manager stand-in ----------------
  logic        force_busy = 1'b0;
  logic        late_en    = 1'b0;
  int          hold[2];
  int          left[2];
  int          waddr[2];
  int          rstcnt[2]  = '{0, 0};
  int          wcnt1      = 0;
  logic [15:0] mem [2][1024];
  logic [15:0] wlog0[$];
  logic [22:0] rlog0[$];
  int          excl_bad   = 0;
  int          aout_bad   = 0;

  assign busy = {force_busy | (hold[1] == 0 && left[1] > 0),
                 force_busy | (hold[0] == 0 && left[0] > 0)};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        hold[i] <= 0;
        left[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fmr[i]) begin
          hold[i]   <= 0;
          left[i]   <= ERASE_CYC;
          waddr[i]  <= 0;
          rstcnt[i] <= rstcnt[i] + 1;
        end else if (dw[i]) begin
          hold[i] <= late_en ? 1 : 0;
          left[i] <= WR_CYC;
          mem[i][waddr[i] % 1024] <= wd[i];
          waddr[i] <= waddr[i] + 1;
          if (i == 0) wlog0.push_back(wd[i]);
          else        wcnt1 <= wcnt1 + 1;
        end else if (dr[i]) begin
          hold[i] <= late_en ? 1 : 0;
          left[i] <= RD_CYC;
          frd[i]  <= mem[i][ra[i] % 1024];
          if (i == 0) rlog0.push_back(ra[i]);
        end else if (hold[i] > 0) begin
          hold[i] <= hold[i] - 1;
        end else if (left[i] > 0) begin
          left[i] <= left[i] - 1;
        end
      end
    end
  end

  // Continuous invariant monitors, checked at the end of the run.
  always @(negedge clk) begin
    excl_bad <= excl_bad + ((dw[0] & dr[0]) ? 1 : 0) + ((dw[1] & dr[1]) ? 1 : 0);
    aout_bad <= aout_bad + ((st[0] != 3'd4 && aout[0] != 18'd0) ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // m = {stop, rec_start, play_start}
  task automatic cmd(input logic [2:0] m);
    @(negedge clk);
    {stop, rec_start, play_start} = m;
    @(negedge clk);
    {stop, rec_start, play_start} = 3'b000;
  endtask

  task automatic strobe(input logic [17:0] s);
    @(negedge clk);
    ready    = 1'b1;
    audio_in = s;
    @(negedge clk);
    ready    = 1'b0;
  endtask

  task automatic wait_state0(input logic [2:0] s, input int max, input string nm);
    int n = 0;
    while (st[0] !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (st[0] !== s) begin
      bad++;
      $display("FAIL %s: state=%0d, want %0d within %0d cycles", nm, st[0], s, max);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++;
    if ({st[0], aout[0], fmr[0], wm[0], wd[0], dw[0], ra[0], dr[0], len[0], fullo[0], xr[0]} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: st=%0d aout=%h fmr=%b wm=%b wd=%h dw=%b ra=%h dr=%b len=%0d full=%b xrun=%b, want all 0",
               st[0], aout[0], fmr[0], wm[0], wd[0], dw[0], ra[0], dr[0], len[0], fullo[0], xr[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_play_empty(input string nm);
    int r0 = rlog0.size();
    cmd(3'b001);
    total++;
    if (st[0] !== 3'd0) begin
      bad++;
      $display("FAIL %s_state: state=%0d, want 0", nm, st[0]);
    end
    strobe(18'h3_ffff);
    tick(5);
    total++;
    if (st[0] !== 3'd0 || rlog0.size() != r0) begin
      bad++;
      $display("FAIL %s_noread: state=%0d reads=%0d, want 0 and %0d", nm, st[0], rlog0.size(), r0);
    end
  endtask

  task automatic test_cmd_priority();
    int rc = rstcnt[0];
    cmd(3'b110);
    total++;
    if (st[0] !== 3'd0 || fmr[0] !== 1'b0) begin
      bad++;
      $display("FAIL stop_rec_priority: state=%0d fm_reset=%b, want 0/0", st[0], fmr[0]);
    end
    tick(3);
    total++;
    if (rstcnt[0] != rc) begin
      bad++;
      $display("FAIL stop_rec_no_erase: erase pulses=%0d, want %0d", rstcnt[0] - rc, 0);
    end
  endtask

  task automatic test_record_fixed();
    int base = wlog0.size();
    int rc   = rstcnt[0];
    cmd(3'b010);
    total++;
    if ({st[0], fmr[0], wm[0]} !== {3'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL erase_pulse: state=%0d fm_reset=%b writemode=%b, want 1/1/1", st[0], fmr[0], wm[0]);
    end
    wait_state0(3'd3, 400, "erase_to_record");
    total++;
    if (rstcnt[0] - rc != 1) begin
      bad++;
      $display("FAIL erase_count: pulses=%0d, want 1", rstcnt[0] - rc);
    end
    for (int k = 0; k < 10; k++) begin
      strobe(18'(12 + 4 * k));
      total++;
      if (dw[0] !== 1'b1 || wd[0] !== 16'(3 + k)) begin
        bad++;
        $display("FAIL write_latency_%0d: dowrite=%b wdata=%0d, want 1/%0d", k, dw[0], wd[0], 3 + k);
      end
      tick($urandom_range(15, 30));
    end
    total++;
    if (wlog0.size() - base != 10) begin
      bad++;
      $display("FAIL write_count: got %0d, want 10", wlog0.size() - base);
    end
    for (int k = 0; k < 10 && base + k < wlog0.size(); k++) begin
      total++;
      if (wlog0[base + k] !== 16'(3 + k)) begin
        bad++;
        $display("FAIL write_data_%0d: got %0d, want %0d", k, wlog0[base + k], 3 + k);
      end
    end
    total++;
    if (len[0] !== 23'd10 || xr[0] !== 1'b0 || fullo[0] !== 1'b0) begin
      bad++;
      $display("FAIL record_status: length=%0d xrun=%b full=%b, want 10/0/0", len[0], xr[0], fullo[0]);
    end
    cmd(3'b100);
    wait_state0(3'd0, 100, "record_stop_idle");
  endtask

  // Loop playback of the words in `words`: strobe k reads address k mod n and
  // presents the word read at strobe k-1 (0 on the first strobe).
  task automatic play_check(input logic [15:0] words[$], input int nstrobes, input string nm);
    int n = words.size();
    logic [17:0] exp;
    cmd(3'b001);
    total++;
    if (st[0] !== 3'd4 || wm[0] !== 1'b0) begin
      bad++;
      $display("FAIL %s_enter: state=%0d writemode=%b, want 4/0", nm, st[0], wm[0]);
    end
    for (int k = 0; k < nstrobes; k++) begin
      strobe(18'($urandom));
      exp = (k == 0) ? 18'd0 : {words[(k - 1) % n], 2'b00};
      total++;
      if (dr[0] !== 1'b1 || ra[0] !== 23'(k % n)) begin
        bad++;
        $display("FAIL %s_read_%0d: doread=%b raddr=%0d, want 1/%0d", nm, k, dr[0], ra[0], k % n);
      end
      total++;
      if (aout[0] !== exp) begin
        bad++;
        $display("FAIL %s_audio_%0d: audio_out=%h, want %h", nm, k, aout[0], exp);
      end
      tick($urandom_range(15, 30));
    end
    cmd(3'b100);
    wait_state0(3'd0, 100, {nm, "_stop_idle"});
    total++;
    if (aout[0] !== 18'd0 || xr[0] !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: audio_out=%h xrun=%b, want 0/0", nm, aout[0], xr[0]);
    end
  endtask

  task automatic test_loop_play();
    logic [15:0] words[$];
    for (int k = 0; k < 10; k++) words.push_back(16'(3 + k));
    play_check(words, 12, "loop_play");
  endtask

  task automatic test_random_session();
    logic [15:0] words[$];
    logic [17:0] s;
    int n    = $urandom_range(3, 12);
    int base = wlog0.size();
    late_en = 1'($urandom_range(0, 1));
    cmd(3'b010);
    wait_state0(3'd3, 400, "rand_record");
    for (int k = 0; k < n; k++) begin
      s = 18'($urandom);
      words.push_back(s[17:2]);
      strobe(s);
      tick($urandom_range(15, 30));
    end
    total++;
    if (wlog0.size() - base != n) begin
      bad++;
      $display("FAIL rand_write_count: got %0d, want %0d", wlog0.size() - base, n);
    end
    for (int k = 0; k < n && base + k < wlog0.size(); k++) begin
      total++;
      if (wlog0[base + k] !== words[k]) begin
        bad++;
        $display("FAIL rand_write_%0d: got %h, want %h", k, wlog0[base + k], words[k]);
      end
    end
    cmd(3'b100);
    wait_state0(3'd0, 100, "rand_stop_idle");
    total++;
    if (len[0] !== 23'(n)) begin
      bad++;
      $display("FAIL rand_length: got %0d, want %0d", len[0], n);
    end
    play_check(words, 2 * n + 1, "rand_play");
    late_en = 1'b0;
  endtask

  task automatic test_capacity();
    int b0 = wlog0.size();
    int b1 = wcnt1;
    cmd(3'b010);
    wait_state0(3'd3, 400, "cap_record");
    for (int k = 0; k < 6; k++) begin
      strobe(18'($urandom));
      tick(20);
    end
    total++;
    if (wcnt1 - b1 != 4 || fullo[1] !== 1'b1 || len[1] !== 23'd4 || st[1] !== 3'd0) begin
      bad++;
      $display("FAIL capacity: writes=%0d full=%b length=%0d state=%0d, want 4/1/4/0",
               wcnt1 - b1, fullo[1], len[1], st[1]);
    end
    total++;
    if (wlog0.size() - b0 != 6 || fullo[0] !== 1'b0) begin
      bad++;
      $display("FAIL capacity_large: writes=%0d full=%b, want 6/0", wlog0.size() - b0, fullo[0]);
    end
    cmd(3'b100);
    wait_state0(3'd0, 100, "cap_stop_idle");
  endtask

  task automatic test_overrun();
    logic [17:0] a, b;
    int base;
    a = 18'($urandom);
    b = 18'($urandom);
    cmd(3'b010);
    wait_state0(3'd3, 400, "xrun_record");
    base = wlog0.size();
    @(negedge clk);
    force_busy = 1'b1;
    strobe(a);
    tick(3);
    strobe(b);
    tick(3);
    total++;
    if (xr[0] !== 1'b1 || wlog0.size() != base) begin
      bad++;
      $display("FAIL xrun_set: xrun=%b writes=%0d, want 1/0", xr[0], wlog0.size() - base);
    end
    force_busy = 1'b0;
    tick(8);
    total++;
    if (wlog0.size() - base != 1 || len[0] !== 23'd1) begin
      bad++;
      $display("FAIL xrun_single_write: writes=%0d length=%0d, want 1/1", wlog0.size() - base, len[0]);
    end else if (wlog0[base] !== b[17:2]) begin
      bad++;
      $display("FAIL xrun_last_sample: wrote %h, want %h", wlog0[base], b[17:2]);
    end
    // ready coincident with stop: no capture, no write
    @(negedge clk);
    ready = 1'b1; stop = 1'b1; audio_in = 18'($urandom);
    @(negedge clk);
    ready = 1'b0; stop = 1'b0;
    wait_state0(3'd0, 100, "ready_stop_idle");
    tick(10);
    total++;
    if (wlog0.size() - base != 1 || len[0] !== 23'd1) begin
      bad++;
      $display("FAIL ready_with_stop: writes=%0d length=%0d, want 1/1", wlog0.size() - base, len[0]);
    end
  endtask

  task automatic test_stop_erase();
    int base = wlog0.size();
    int rc   = rstcnt[0];
    cmd(3'b010);
    tick(5);
    total++;
    if (st[0] !== 3'd2) begin
      bad++;
      $display("FAIL erase_wait_state: state=%0d, want 2", st[0]);
    end
    cmd(3'b100);
    total++;
    if (st[0] !== 3'd2) begin
      bad++;
      $display("FAIL erase_not_aborted: state=%0d, want 2", st[0]);
    end
    strobe(18'($urandom));
    wait_state0(3'd0, 300, "erase_stop_idle");
    strobe(18'($urandom));
    tick(10);
    total++;
    if (wlog0.size() != base || rstcnt[0] - rc != 1 || len[0] !== 23'd0 || st[0] !== 3'd0) begin
      bad++;
      $display("FAIL erase_stop: writes=%0d erases=%0d length=%0d state=%0d, want 0/1/0/0",
               wlog0.size() - base, rstcnt[0] - rc, len[0], st[0]);
    end
  endtask

  task automatic test_reset_mid_record();
    cmd(3'b010);
    wait_state0(3'd3, 400, "rst_record");
    strobe(18'($urandom));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({st[0], aout[0], fmr[0], wm[0], wd[0], dw[0], ra[0], dr[0], len[0], fullo[0], xr[0]} !== '0) begin
      bad++;
      $display("FAIL reset_mid_record: st=%0d wm=%b wd=%h dw=%b len=%0d, want all 0",
               st[0], wm[0], wd[0], dw[0], len[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    test_play_empty("play_after_reset");
  endtask

  task automatic test_invariants();
    total++;
    if (excl_bad != 0) begin
      bad++;
      $display("FAIL read_write_exclusive: %0d cycles with both pulses, want 0", excl_bad);
    end
    total++;
    if (aout_bad != 0) begin
      bad++;
      $display("FAIL audio_zero_outside_play: %0d cycles nonzero, want 0", aout_bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    audio_in = '0;
    test_reset();
    test_play_empty("play_empty");
    test_cmd_priority();
    test_record_fixed();
    test_loop_play();
    test_random_session();
    test_capacity();
    test_overrun();
    test_stop_erase();
    test_reset_mid_record();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
